// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the sequential calculator.
//   op_e       - op_select encodings
//   state_e    - controller FSM states
//   iter_count - number of CALC cycles spent by the iterative mul/div/mod ops
package calc_pkg;

    typedef enum logic [3:0] {
        OpAdd = 4'b0000,
        OpSub = 4'b0001,
        OpMul = 4'b0010,
        OpDiv = 4'b0011,
        OpMod = 4'b0100,
        OpAnd = 4'b0101,
        OpOr  = 4'b0110,
        OpXor = 4'b0111,
        OpShl = 4'b1000,
        OpShr = 4'b1001
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

    // One shift-add or restoring-division step per operand bit.
    function automatic int unsigned iter_count(input int unsigned nbits);
        return nbits;
    endfunction

endpackage

// File: rtl/calc_divider.sv
// calc_divider: iterative restoring divider, one quotient bit per step.
//   clock, reset_n      - clock, asynchronous active-low reset
//   start               - load dividend/divisor and clear the partial remainder
//   step                - perform one division step this cycle
//   dividend, divisor   - unsigned operands sampled on start
//   quotient, remainder - values the registers take after this cycle's step,
//                         so the owner can capture them on the final step's edge
//   div0                - the loaded divisor is zero
module calc_divider
    import calc_pkg::*;
#(
    parameter int unsigned NBITS = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             step,
    input  logic [NBITS-1:0] dividend,
    input  logic [NBITS-1:0] divisor,
    output logic [NBITS-1:0] quotient,
    output logic [NBITS-1:0] remainder,
    output logic             div0
);

    logic [NBITS-1:0] quo_q, rem_q, dsr_q;
    logic [NBITS:0]   trial, diff;

    always_comb begin
        trial = {rem_q, quo_q[NBITS-1]};
        diff  = trial - {1'b0, dsr_q};
        // The partial remainder stays below the divisor, so bit NBITS of diff
        // is set exactly when the trial subtraction went negative.
        if (diff[NBITS]) begin
            remainder = trial[NBITS-1:0];
            quotient  = {quo_q[NBITS-2:0], 1'b0};
        end else begin
            remainder = diff[NBITS-1:0];
            quotient  = {quo_q[NBITS-2:0], 1'b1};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            quo_q <= '0;
            rem_q <= '0;
            dsr_q <= '0;
        end else if (start) begin
            quo_q <= dividend;
            rem_q <= '0;
            dsr_q <= divisor;
        end else if (step) begin
            quo_q <= quotient;
            rem_q <= remainder;
        end
    end

    assign div0 = (dsr_q == '0);

endmodule

// File: rtl/seq_calculator.sv
// seq_calculator: multi-cycle unsigned ALU with valid/ready request and result.
//   clock, reset_n         - clock, asynchronous active-low reset
//   start_valid/ready      - request handshake (ready only in IDLE)
//   op_select              - opcode (calc_pkg::op_e); other codes flag err
//   operand1, operand2     - NBITS unsigned operands
//   resultado, err         - 2*NBITS result and error flag, valid with res_valid
//   res_valid/res_ready    - result handshake, result held until accepted
//   busy                   - FSM not in IDLE
// Optional (CALC_STATUS_FLAGS_EN defined):
//   zero_flag, carry_flag  - result==0, add carry-out / sub borrow
module seq_calculator
    import calc_pkg::*;
#(
    parameter int unsigned NBITS = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [3:0]         op_select,
    input  logic [NBITS-1:0]   operand1,
    input  logic [NBITS-1:0]   operand2,
    output logic [2*NBITS-1:0] resultado,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               err,
    output logic               busy
`ifdef CALC_STATUS_FLAGS_EN
    ,
    output logic               zero_flag,
    output logic               carry_flag
`endif
);

    localparam int unsigned W     = 2 * NBITS;
    localparam int unsigned Iters = iter_count(NBITS);
    localparam int unsigned CntW  = $clog2(Iters);

    state_e           state_q, state_d;
    logic [3:0]       op_q;
    logic [NBITS-1:0] a_q, b_q;
    logic [W-1:0]     acc_q;      // mul: {partial product high, remaining multiplier}
    logic [CntW-1:0]  cnt_q;
    logic [W-1:0]     res_q, res_d;
    logic             err_q, err_d;

    logic             accept, iterative, last_iter;
    logic [NBITS:0]   mul_sum;
    logic [W-1:0]     mul_next, a_ext, b_ext;
    logic [NBITS-1:0] div_quo, div_rem;
    logic             div0;

    assign accept    = start_valid && (state_q == StIdle);
    assign last_iter = (cnt_q == CntW'(Iters - 1));
    assign iterative = (op_q == OpMul) || (((op_q == OpDiv) || (op_q == OpMod)) && !div0);
    assign a_ext     = {{NBITS{1'b0}}, a_q};
    assign b_ext     = {{NBITS{1'b0}}, b_q};

    // Shift-add step: add multiplicand to the high half when the multiplier
    // LSB is set, then shift the whole accumulator right by one.
    assign mul_sum  = {1'b0, acc_q[W-1:NBITS]} + (acc_q[0] ? {1'b0, a_q} : '0);
    assign mul_next = {mul_sum, acc_q[NBITS-1:1]};

    calc_divider #(
        .NBITS (NBITS)
    ) u_divider (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (accept),
        .step      (state_q == StCalc),
        .dividend  (operand1),
        .divisor   (operand2),
        .quotient  (div_quo),
        .remainder (div_rem),
        .div0      (div0)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_valid) state_d = StCalc;
            StCalc:  if (!iterative || last_iter) state_d = StDone;
            StDone:  if (res_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        res_d = '0;
        err_d = 1'b0;
        case (op_q)
            OpAdd: res_d = a_ext + b_ext;
            OpSub: res_d = a_ext - b_ext;
            OpMul: res_d = mul_next;
            OpDiv: begin
                if (div0) begin
                    res_d = {{NBITS{1'b0}}, {NBITS{1'b1}}};
                    err_d = 1'b1;
                end else begin
                    res_d = {{NBITS{1'b0}}, div_quo};
                end
            end
            OpMod: begin
                if (div0) begin
                    res_d = a_ext;
                    err_d = 1'b1;
                end else begin
                    res_d = {{NBITS{1'b0}}, div_rem};
                end
            end
            OpAnd: res_d = a_ext & b_ext;
            OpOr:  res_d = a_ext | b_ext;
            OpXor: res_d = a_ext ^ b_ext;
            // Shifts by W or more yield zero under SV shift semantics.
            OpShl: res_d = a_ext << b_q;
            OpShr: res_d = a_ext >> b_q;
            default: err_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= op_select;
                a_q   <= operand1;
                b_q   <= operand2;
                acc_q <= {{NBITS{1'b0}}, operand2};
                cnt_q <= '0;
            end else if (state_q == StCalc) begin
                cnt_q <= cnt_q + 1'b1;
                acc_q <= mul_next;
                if (state_d == StDone) begin
                    res_q <= res_d;
                    err_q <= err_d;
                end
            end
        end
    end

`ifdef CALC_STATUS_FLAGS_EN
    logic zero_q, carry_q, carry_d;

    always_comb begin
        carry_d = 1'b0;
        if (op_q == OpAdd) carry_d = res_d[NBITS];
        else if (op_q == OpSub) carry_d = (a_q < b_q);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else if ((state_q == StCalc) && (state_d == StDone)) begin
            zero_q  <= (res_d == '0);
            carry_q <= carry_d;
        end
    end

    assign zero_flag  = zero_q;
    assign carry_flag = carry_q;
`endif

    assign start_ready = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign res_valid   = (state_q == StDone);
    assign resultado   = res_q;
    assign err         = err_q;

endmodule

// File: tb/tb_seq_calculator.sv
// tb_seq_calculator: directed scoreboard bench for seq_calculator (NBITS=4).
// Expectations are pushed at acceptance; a monitor compares whenever
// res_valid is high and retires the entry on the res_valid&&res_ready edge.
// Build with CALC_STATUS_FLAGS_EN defined to also check zero_flag/carry_flag.
module tb_seq_calculator;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start_valid = 1'b0;
    logic       res_ready = 1'b1;
    logic [3:0] op_select = '0;
    logic [3:0] operand1 = '0;
    logic [3:0] operand2 = '0;
    logic [7:0] resultado;
    logic       start_ready, res_valid, err, busy;
`ifdef CALC_STATUS_FLAGS_EN
    logic       zero_flag, carry_flag;
`endif

    seq_calculator #(
        .NBITS (4)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_select   (op_select),
        .operand1    (operand1),
        .operand2    (operand2),
        .resultado   (resultado),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .err         (err),
        .busy        (busy)
`ifdef CALC_STATUS_FLAGS_EN
        ,
        .zero_flag   (zero_flag),
        .carry_flag  (carry_flag)
`endif
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] res;
        logic       err;
        logic       zf;
        logic       cf;
        int         lat;   // cycles spent in CALC
        int         acc;   // cyc value just after the acceptance edge
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    bit   seen = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Compare on the falling edge, away from DUT updates.
    always @(negedge clock) begin
        if (reset_n && res_valid) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_res_valid: got res_valid=1 resultado=%0h, expected no result",
                         resultado);
            end else begin
                mon_e = sb[0];
                if (!seen) chk("latency", cyc - mon_e.acc, mon_e.lat);
                chk("resultado", resultado, mon_e.res);
                chk("err", err, mon_e.err);
`ifdef CALC_STATUS_FLAGS_EN
                chk("zero_flag", zero_flag, mon_e.zf);
                chk("carry_flag", carry_flag, mon_e.cf);
`endif
                seen = 1'b1;
            end
        end
    end

    // Retire on the handshake edge (pre-edge values).
    always @(posedge clock) begin
        if (reset_n && res_valid && res_ready && sb.size() > 0) begin
            void'(sb.pop_front());
            seen = 1'b0;
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] r, input logic e, input logic zf, input logic cf,
                         input int lat);
        int i = 0;
        while (!start_ready && i < 100) begin
            @(negedge clock);
            i++;
        end
        if (!start_ready) begin
            n_total++;
            $display("FAIL issue_timeout: got start_ready=0 for 100 cycles, expected 1");
            return;
        end
        start_valid = 1'b1;
        op_select   = op;
        operand1    = a;
        operand2    = b;
        @(negedge clock);
        sb.push_back('{r, e, zf, cf, lat, cyc});
        // Scramble inputs to show they are ignored while busy.
        start_valid = 1'b0;
        op_select   = 4'($urandom);
        operand1    = 4'($urandom);
        operand2    = 4'($urandom);
    endtask

    task automatic drain();
        int i = 0;
        while (sb.size() > 0 && i < 200) begin
            @(negedge clock);
            i++;
        end
        if (sb.size() > 0) begin
            n_total++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
        end
    endtask

    initial begin
        int i;
        #1;
        chk("rst_start_ready", start_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_resultado", resultado, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        //    op       a      b      res    err zf cf lat
        issue(4'b0000, 4'h1, 4'h1, 8'h02, 0, 0, 0, 1);  // add
        issue(4'b0010, 4'hF, 4'hF, 8'hE1, 0, 0, 0, 4);  // mul
        issue(4'b0011, 4'hD, 4'h3, 8'h04, 0, 0, 0, 4);  // div
        issue(4'b0100, 4'hD, 4'h3, 8'h01, 0, 0, 0, 4);  // mod
        issue(4'b0011, 4'h5, 4'h0, 8'h0F, 1, 0, 0, 1);  // div by zero
        issue(4'b0100, 4'h7, 4'h0, 8'h07, 1, 0, 0, 1);  // mod by zero
        issue(4'b1111, 4'h6, 4'h2, 8'h00, 1, 1, 0, 1);  // illegal
        issue(4'b0001, 4'h2, 4'h3, 8'hFF, 0, 0, 1, 1);  // sub with borrow
        issue(4'b0001, 4'h9, 4'h4, 8'h05, 0, 0, 0, 1);  // sub no borrow
        issue(4'b0111, 4'h5, 4'h5, 8'h00, 0, 1, 0, 1);  // xor -> zero
        issue(4'b0000, 4'hF, 4'hF, 8'h1E, 0, 0, 1, 1);  // add with carry
        issue(4'b1000, 4'h3, 4'h3, 8'h18, 0, 0, 0, 1);  // shl
        issue(4'b1001, 4'hC, 4'h2, 8'h03, 0, 0, 0, 1);  // shr
        issue(4'b1000, 4'h1, 4'h8, 8'h00, 0, 1, 0, 1);  // shl by 2*NBITS
        issue(4'b0101, 4'hC, 4'hA, 8'h08, 0, 0, 0, 1);  // and
        issue(4'b0110, 4'hC, 4'hA, 8'h0E, 0, 0, 0, 1);  // or
        issue(4'b0010, 4'h3, 4'h5, 8'h0F, 0, 0, 0, 4);  // mul
        issue(4'b0011, 4'hE, 4'hF, 8'h00, 0, 1, 0, 4);  // div, divisor > dividend
        issue(4'b0100, 4'hE, 4'hF, 8'h0E, 0, 0, 0, 4);  // mod, divisor > dividend
        drain();

        // Backpressure: result held, new requests ignored, bubble before next accept.
        res_ready = 1'b0;
        issue(4'b0000, 4'h4, 4'h5, 8'h09, 0, 0, 0, 1);
        i = 0;
        while (!res_valid && i < 20) begin
            @(negedge clock);
            i++;
        end
        start_valid = 1'b1;
        op_select   = 4'b0000;
        operand1    = 4'h2;
        operand2    = 4'h2;
        for (int k = 0; k < 3; k++) begin
            chk("hold_res_valid", res_valid, 1);
            chk("hold_start_ready", start_ready, 0);
            chk("hold_busy", busy, 1);
            @(negedge clock);
        end
        res_ready = 1'b1;
        @(negedge clock);
        chk("bubble_start_ready", start_ready, 1);
        chk("bubble_res_valid", res_valid, 0);
        chk("bubble_busy", busy, 0);
        @(negedge clock);
        sb.push_back('{8'h04, 1'b0, 1'b0, 1'b0, 1, cyc});
        start_valid = 1'b0;
        drain();

        // Reset during the second mul iteration aborts without a result.
        issue(4'b0010, 4'hF, 4'hF, 8'hE1, 0, 0, 0, 4);
        @(negedge clock);
        reset_n = 1'b0;
        sb.delete();
        seen = 1'b0;
        #1;
        chk("abort_start_ready", start_ready, 1);
        chk("abort_res_valid", res_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_err", err, 0);
        chk("abort_resultado", resultado, 0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (6) @(negedge clock);
        chk("post_reset_idle", start_ready, 1);
        issue(4'b0000, 4'h3, 4'h4, 8'h07, 0, 0, 0, 1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seq_calculator.md
SEQ_CALCULATOR -- requirements
Module: seq_calculator

Interface
REQ-001 The block SHALL have parameter NBITS, default 4, giving the operand width (legal range 2..32).
REQ-002 The block SHALL have port clock, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit, the asynchronous active-low reset.
REQ-004 The block SHALL have port start_valid, input, 1 bit, indicating that a request is offered.
REQ-005 The block SHALL have port start_ready, output, 1 bit, indicating that the block can accept a request.
REQ-006 The block SHALL have port op_select, input, 4 bits, the operation code.
REQ-007 The block SHALL have ports operand1 and operand2, input, NBITS each, the unsigned operands.
REQ-008 The block SHALL have port resultado, output, 2*NBITS, the result.
REQ-009 The block SHALL have port res_valid, output, 1 bit, indicating that resultado and err are valid.
REQ-010 The block SHALL have port res_ready, input, 1 bit, the consumer acknowledge.
REQ-011 The block SHALL have port err, output, 1 bit, flagging divide-by-zero or an illegal opcode.
REQ-012 The block SHALL have port busy, output, 1 bit, high in any state other than IDLE.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, CALC and DONE; start_ready SHALL be 1 only in IDLE.
REQ-014 Acceptance SHALL occur on the edge where start_valid=1 and start_ready=1: op_select and both operands are captured, and the FSM goes to CALC.
REQ-015 The opcodes SHALL be: 0000 add, 0001 sub, 0010 mul, 0011 div, 0100 mod, 0101 and, 0110 or, 0111 xor, 1000 shl, 1001 shr; all others are illegal.
REQ-016 The result rules SHALL be:
- add: zero-extended sum, with the carry at bit NBITS.
- sub: 2*NBITS modular difference of the zero-extended operands.
- logic ops: zero-extended.
- shl/shr: operand1 zero-extended and shifted by operand2; a shift amount >= 2*NBITS gives 0.
REQ-017 Single-cycle ops (add, sub, logic, shifts, illegal opcode, div/mod by zero) SHALL spend 1 cycle in CALC, so res_valid rises on the 2nd edge after acceptance.
REQ-018 mul SHALL be iterative shift-add and div/mod SHALL be iterative restoring division, each spending exactly NBITS cycles in CALC, so res_valid rises on edge NBITS+1 after acceptance.
REQ-019 div SHALL return the zero-extended quotient and mod SHALL return the zero-extended remainder.
REQ-020 For div/mod with operand2=0 the block SHALL return quotient all-ones (NBITS bits, zero-extended) or remainder = operand1, with err=1.
REQ-021 An illegal opcode SHALL return resultado=0 with err=1.
REQ-022 In DONE, res_valid=1 and resultado/err SHALL be held stable until res_ready=1; the FSM then returns to IDLE on that edge.
REQ-023 A new request SHALL NOT be accepted on the same edge as a DONE-to-IDLE transition (one bubble cycle minimum).
REQ-024 Input changes while busy=1 SHALL NOT affect the computation in progress.

Reset
REQ-025 While reset_n=0, regardless of the clock, the FSM SHALL be in IDLE with start_ready=1, res_valid=0, busy=0, err=0, resultado=0, and the iteration counter and datapath registers cleared.
REQ-026 Reset asserted mid-operation SHALL abort the operation with no result delivered; the first acceptance after release SHALL behave as from power-up.

Configuration
REQ-027 With CALC_STATUS_FLAGS_EN defined, the block SHALL add output ports zero_flag (resultado==0) and carry_flag (add carry-out, or sub borrow when operand1<operand2, else 0), both valid with res_valid, held in DONE, and reset to 0.
REQ-028 Without CALC_STATUS_FLAGS_EN, these ports and their logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-029 A package calc_pkg SHALL hold the op_select encodings as an enum, the FSM state enum and the mul/div iteration count helper.
REQ-030 The iterative restoring divider SHALL be a sub-module calc_divider (start, NBITS-cycle run, quotient/remainder outputs, div0 detect); mul shift-add SHALL stay in the top module.

Verification (NBITS=4)
REQ-031 add 0001+0001 with res_ready=1 -> resultado=00000010, err=0, res_valid on the 2nd edge after acceptance.
REQ-032 mul 1111*1111 -> resultado=11100001 after 4 CALC cycles; div 1101/0011 -> 00000100; mod 1101/0011 -> 00000001.
REQ-033 div 0101/0000 -> resultado=00001111, err=1, single-cycle latency; opcode 1111 -> resultado=0, err=1.
REQ-034 res_ready held 0 for 3 cycles after res_valid -> resultado stable, start_ready=0, start_valid ignored; res_ready=1 -> IDLE next edge.
REQ-035 reset_n pulsed low during the 2nd mul iteration -> all outputs at reset values immediately, no res_valid; the next add completes correctly.
REQ-036 With CALC_STATUS_FLAGS_EN: sub 0010-0011 -> resultado=11111111, carry_flag=1, zero_flag=0; xor 0101^0101 -> zero_flag=1.
